// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_IO  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for the memory arbiter.
// ARB_ROUND_ROBIN_EN selects round-robin on contention; default is fixed priority to port 0.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic valid,
  output logic winner
);

  assign valid = req0 | req1;

`ifdef ARB_ROUND_ROBIN_EN
  // On contention the port that was not granted last takes its turn.
  always_comb begin
    if (req0 && req1) begin
      winner = ~last_gnt;
    end else begin
      winner = req1 ? PORT_IO : PORT_CPU;
    end
  end
`else
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
  assign winner = req0 ? PORT_CPU : (req1 ? PORT_IO : PORT_CPU);
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between a CPU port (0) and an I/O/DMA port (1).
// Optional round-robin arbitration is enabled with the ARB_ROUND_ROBIN_EN macro.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ0,
  input  logic          WE0,
  input  logic [AW-1:0] ADDR0,
  input  logic [DW-1:0] WDATA0,
  output logic          GNT0,
  output logic          DONE0,
  output logic [DW-1:0] RDATA0,
  input  logic          REQ1,
  input  logic          WE1,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WDATA1,
  output logic          GNT1,
  output logic          DONE1,
  output logic [DW-1:0] RDATA1,
  output logic [AW-1:0] MEM_ADDRESS,
  output logic [DW-1:0] MEM_DATA_IN,
  output logic          MEM_WRITE,
  output logic          MEM_READ,
  input  logic [DW-1:0] MEM_DATA_OUT,
  output logic          BUSY
);

  state_t state_q, state_d;
  logic   accept;
  logic   owner_q;
  logic   we_q;
  logic   pick_valid;
  logic   pick_winner;
  logic   last_gnt;
  logic   in_access;
  logic   in_resp;

  mem_arb_pick u_pick (
    .req0     (REQ0),
    .req1     (REQ1),
    .last_gnt (last_gnt),
    .valid    (pick_valid),
    .winner   (pick_winner)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE, RESP: begin
        if (pick_valid) begin
          state_d = ACCESS;
          accept  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // The winner's request fields are held here for the whole access.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      owner_q     <= PORT_CPU;
      we_q        <= 1'b0;
      MEM_ADDRESS <= '0;
      MEM_DATA_IN <= '0;
    end else if (accept) begin
      owner_q     <= pick_winner;
      we_q        <= (pick_winner == PORT_IO) ? WE1    : WE0;
      MEM_ADDRESS <= (pick_winner == PORT_IO) ? ADDR1  : ADDR0;
      MEM_DATA_IN <= (pick_winner == PORT_IO) ? WDATA1 : WDATA0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RDATA0 <= '0;
      RDATA1 <= '0;
    end else if (in_access && !we_q) begin
      if (owner_q == PORT_CPU) RDATA0 <= MEM_DATA_OUT;
      else                     RDATA1 <= MEM_DATA_OUT;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Reset to port 1 so that port 0 wins the first contention.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         last_gnt <= PORT_IO;
    else if (accept) last_gnt <= pick_winner;
  end
`else
  assign last_gnt = PORT_IO;
`endif

  // Decoding from the state register lets a reset during ACCESS drop MEM_WRITE at once.
  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);

  assign GNT0      = in_access && (owner_q == PORT_CPU);
  assign GNT1      = in_access && (owner_q == PORT_IO);
  assign DONE0     = in_resp   && (owner_q == PORT_CPU);
  assign DONE1     = in_resp   && (owner_q == PORT_IO);
  assign MEM_WRITE = in_access &&  we_q;
  assign MEM_READ  = in_access && !we_q;
  assign BUSY      = in_access || in_resp;

endmodule
